// File: rtl/rv_brick_ctl.sv
// Issue-side brick stall controller: loads a block count on an issued brick, stalls issue until it drains or the owning thread flushes.
// Optional: define RV_BRICK_PERF_EN to add the 16-bit saturating brick_perf_cnt output.
module rv_brick_ctl #(
    parameter int THREADS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_v,
    input  logic [0:THREADS-1] iss_tid,
    input  logic               iss_is_brick,
    input  logic [2:0]         iss_brick_cycles,
    input  logic [0:THREADS-1] cp_flush,
    input  logic               err_clr,
    output logic               brick_block,
    output logic [0:THREADS-1] brick_tid,
    output logic [3:0]         brick_cnt,
    output logic               brick_err
`ifdef RV_BRICK_PERF_EN
    ,
    output logic [15:0]        brick_perf_cnt
`endif
);

    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [0:THREADS-1] r_own;
    logic [0:THREADS-1] w_own_nxt;
    logic               r_block;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_iss_eff;
    logic               w_own_flush;
    logic               w_active;

    assign w_iss_eff   = iss_v & ~(|(iss_tid & cp_flush));
    assign w_own_flush = |(r_own & cp_flush);
    assign w_active    = (r_cnt != 4'd0);

    // An active brick ignores every issue; only an owner flush or the count draining frees it.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_own_nxt = r_own;
        if (w_active) begin
            if (w_own_flush) begin
                w_cnt_nxt = 4'd0;
                w_own_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_own_nxt = '0;
                end
            end
        end else if (w_iss_eff && iss_is_brick) begin
            w_cnt_nxt = {1'b0, iss_brick_cycles} + 4'd1;
            w_own_nxt = iss_tid;
        end
    end

    always_comb begin
        w_err_nxt = r_err;
        if (iss_v && r_block) begin
            w_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_err_nxt = 1'b0;
        end
    end

    // Block is kept as its own flop so the stall output has no decode after the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_own   <= '0;
            r_block <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_own   <= w_own_nxt;
            r_block <= (w_cnt_nxt != 4'd0);
            r_err   <= w_err_nxt;
        end
    end

    assign brick_block = r_block;
    assign brick_tid   = r_own;
    assign brick_cnt   = r_cnt;
    assign brick_err   = r_err;

`ifdef RV_BRICK_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= 16'd0;
        end else if (err_clr) begin
            r_perf <= 16'd0;
        end else if (r_block && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign brick_perf_cnt = r_perf;
`endif

endmodule

// File: tb/tb_rv_brick_ctl.sv
// Scoreboard bench for rv_brick_ctl: directed per-cycle vectors push hand-computed expected outputs, a monitor pops and compares.
module tb_rv_brick_ctl;

    // Thread vectors are [0:1], so thread 0 is the leftmost bit of the literal.
    localparam logic [0:1] T0 = 2'b10;
    localparam logic [0:1] T1 = 2'b01;
    localparam logic [0:1] TZ = 2'b00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iss_v = 1'b0;
    logic [0:1] iss_tid = 2'b00;
    logic       iss_is_brick = 1'b0;
    logic [2:0] iss_brick_cycles = 3'd0;
    logic [0:1] cp_flush = 2'b00;
    logic       err_clr = 1'b0;
    logic       brick_block;
    logic [0:1] brick_tid;
    logic [3:0] brick_cnt;
    logic       brick_err;
`ifdef RV_BRICK_PERF_EN
    logic [15:0] brick_perf_cnt;
`endif

    rv_brick_ctl #(.THREADS(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .iss_v            (iss_v),
        .iss_tid          (iss_tid),
        .iss_is_brick     (iss_is_brick),
        .iss_brick_cycles (iss_brick_cycles),
        .cp_flush         (cp_flush),
        .err_clr          (err_clr),
        .brick_block      (brick_block),
        .brick_tid        (brick_tid),
        .brick_cnt        (brick_cnt),
        .brick_err        (brick_err)
`ifdef RV_BRICK_PERF_EN
        ,
        .brick_perf_cnt   (brick_perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        string      nm;
        logic       blk;
        logic [0:1] tid;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        exp_t e;
        #2;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if ({brick_block, brick_tid, brick_cnt, brick_err} !== {e.blk, e.tid, e.cnt, e.err}) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got blk=%b tid=%b cnt=%0d err=%b want blk=%b tid=%b cnt=%0d err=%b",
                         e.nm, cyc, brick_block, brick_tid, brick_cnt, brick_err, e.blk, e.tid, e.cnt, e.err);
            end
        end
    end

    task automatic step(input string nm, input logic v, input logic [0:1] tid, input logic brk,
                        input logic [2:0] c, input logic [0:1] fl, input logic clr,
                        input logic eb, input logic [0:1] et, input logic [3:0] ec, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        iss_v            = v;
        iss_tid          = tid;
        iss_is_brick     = brk;
        iss_brick_cycles = c;
        cp_flush         = fl;
        err_clr          = clr;
        e.due = cyc + 1;
        e.nm  = nm;
        e.blk = eb;
        e.tid = et;
        e.cnt = ec;
        e.err = ee;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic eb, input logic [0:1] et, input logic [3:0] ec, input logic ee);
        step(nm, 1'b0, TZ, 1'b0, 3'd0, TZ, 1'b0, eb, et, ec, ee);
    endtask

    task automatic chk_zero(input string nm);
        n_cmp++;
        if ({brick_block, brick_tid, brick_cnt, brick_err} !== 8'd0) begin
            n_bad++;
            $display("FAIL %s got blk=%b tid=%b cnt=%0d err=%b want all zero",
                     nm, brick_block, brick_tid, brick_cnt, brick_err);
        end
    endtask

    initial begin
        #7;
        chk_zero("reset_state");
        #5 rst_n = 1'b1;

        // c=0 on thread 0: one blocked cycle.
        step("c0_load", 1, T0, 1, 3'd0, TZ, 0, 1, T0, 4'd1, 0);
        idle("c0_drop", 0, TZ, 4'd0, 0);
        idle("c0_idle", 0, TZ, 4'd0, 0);

        // c=7 on thread 1, then a legal back-to-back brick the cycle the block drops.
        step("c7_load", 1, T1, 1, 3'd7, TZ, 0, 1, T1, 4'd8, 0);
        for (int k = 7; k >= 1; k--) idle("c7_dec", 1, T1, 4'(k), 0);
        idle("c7_drop", 0, TZ, 4'd0, 0);
        step("b2b_load", 1, T0, 1, 3'd2, TZ, 0, 1, T0, 4'd3, 0);
        idle("b2b_dec", 1, T0, 4'd2, 0);
        idle("b2b_dec", 1, T0, 4'd1, 0);
        idle("b2b_drop", 0, TZ, 4'd0, 0);

        // Owner flush releases; non-owner flush is ignored.
        step("fl_load", 1, T0, 1, 3'd5, TZ, 0, 1, T0, 4'd6, 0);
        idle("fl_dec", 1, T0, 4'd5, 0);
        step("fl_owner", 0, TZ, 0, 3'd0, T0, 0, 0, TZ, 4'd0, 0);
        step("nf_load", 1, T0, 1, 3'd5, TZ, 0, 1, T0, 4'd6, 0);
        step("nf_other", 0, TZ, 0, 3'd0, T1, 0, 1, T0, 4'd5, 0);
        for (int k = 4; k >= 1; k--) idle("nf_dec", 1, T0, 4'(k), 0);
        idle("nf_drop", 0, TZ, 4'd0, 0);

        // Violations, error clear, and clear racing a new violation.
        step("er_load", 1, T0, 1, 3'd5, TZ, 0, 1, T0, 4'd6, 0);
        step("er_viol", 1, T1, 0, 3'd0, TZ, 0, 1, T0, 4'd5, 1);
        idle("er_hold", 1, T0, 4'd4, 1);
        step("er_clr", 0, TZ, 0, 3'd0, TZ, 1, 1, T0, 4'd3, 0);
        step("er_clr_set", 1, T0, 1, 3'd7, TZ, 1, 1, T0, 4'd2, 1);
        step("er_clr2", 0, TZ, 0, 3'd0, TZ, 1, 1, T0, 4'd1, 0);
        idle("er_drop", 0, TZ, 4'd0, 0);

        // Issue in the cycle the count goes 1->0 is a violation and is dropped.
        step("edge_load", 1, T1, 1, 3'd1, TZ, 0, 1, T1, 4'd2, 0);
        idle("edge_dec", 1, T1, 4'd1, 0);
        step("edge_viol", 1, T0, 1, 3'd3, TZ, 0, 0, TZ, 4'd0, 1);
        step("edge_clr", 0, TZ, 0, 3'd0, TZ, 1, 0, TZ, 4'd0, 0);

        // A flushed issue during a block is still a violation; its flush hits a non-owner.
        step("fv_load", 1, T0, 1, 3'd2, TZ, 0, 1, T0, 4'd3, 0);
        step("fv_viol", 1, T1, 1, 3'd4, T1, 0, 1, T0, 4'd2, 1);
        step("fv_clr", 0, TZ, 0, 3'd0, TZ, 1, 1, T0, 4'd1, 0);
        idle("fv_drop", 0, TZ, 4'd0, 0);

        // Same-cycle flush drops the issue; non-brick idle issue does nothing; cross-thread flush does not.
        step("self_flush", 1, T0, 1, 3'd4, T0, 0, 0, TZ, 4'd0, 0);
        step("nonbrick", 1, T1, 0, 3'd6, TZ, 0, 0, TZ, 4'd0, 0);
        step("xflush_load", 1, T1, 1, 3'd3, T0, 0, 1, T1, 4'd4, 0);
        step("xflush_own", 0, TZ, 0, 3'd0, T1, 0, 0, TZ, 4'd0, 0);
        idle("xflush_idle", 0, TZ, 4'd0, 0);

        // Asynchronous reset mid-brick, then a c=1 brick blocks exactly two cycles.
        step("rs_load", 1, T0, 1, 3'd7, TZ, 0, 1, T0, 4'd8, 0);
        idle("rs_dec", 1, T0, 4'd7, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        #2 rst_n = 1'b1;
        step("post_load", 1, T1, 1, 3'd1, TZ, 0, 1, T1, 4'd2, 0);
        idle("post_dec", 1, T1, 4'd1, 0);
        idle("post_drop", 0, TZ, 4'd0, 0);

        repeat (3) @(posedge clk);
        #4;
`ifdef RV_BRICK_PERF_EN
        n_cmp++;
        if (brick_perf_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL perf_cnt got %0d want 2", brick_perf_cnt);
        end
`endif
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
